// File: rtl/ky32_regfile.sv
// ky32_regfile: KY32 integer register file, NREG x XLEN, 2 combinational read ports, 1 write port,
//   plus a per-register pending scoreboard for read-after-write hazard detection at issue.
// Latency: writes and scoreboard updates take effect on the next clk rising edge; reads are combinational.
// Ports: clk/rst_n (sync active-low reset); we/waddr/wdata writeback; raddr1/2 -> rdata1/2 operands;
//   iss_valid/iss_rd mark a destination pending; pend1/2 report pending state of raddr1/2.
// Optional: define KY32_RF_BYPASS_EN for write-through of data and pending-clear to the read ports.
module ky32_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5    // 2**AW must equal NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            pend1,
  output logic            pend2
);

  // Storage and scoreboard state
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // A write that actually lands: register 0 is never written.
  logic wr_hit;
  logic iss_hit;
  assign wr_hit  = we && (waddr != '0);
  assign iss_hit = iss_valid && (iss_rd != '0);

  // Data next state
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[waddr] = wdata;
    end
  end

  // Scoreboard next state. The issue set is applied after the writeback
  // clear so that a same-edge set/clear of one register leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (we) begin
      pend_d[waddr] = 1'b0;
    end
    if (iss_hit) begin
      pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State registers; reset overrides any concurrent write or issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Stored-state read values; register 0 reads zero regardless of storage.
  logic [XLEN-1:0] rd_stored1;
  logic [XLEN-1:0] rd_stored2;
  logic            pd_stored1;
  logic            pd_stored2;

  always_comb begin
    rd_stored1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    rd_stored2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    pd_stored1 = pend_q[raddr1];
    pd_stored2 = pend_q[raddr2];
  end

`ifdef KY32_RF_BYPASS_EN
  // Write-through: a landing write to the address being read is forwarded
  // in the same cycle, and its pending bit is seen as already cleared unless
  // a new issue to that same register arrives in this cycle.
  logic byp1;
  logic byp2;
  assign byp1 = rst_n && wr_hit && (raddr1 == waddr);
  assign byp2 = rst_n && wr_hit && (raddr2 == waddr);

  always_comb begin
    rdata1 = rd_stored1;
    rdata2 = rd_stored2;
    pend1  = pd_stored1;
    pend2  = pd_stored2;
    if (byp1) begin
      rdata1 = wdata;
      pend1  = iss_valid && (iss_rd == raddr1);
    end
    if (byp2) begin
      rdata2 = wdata;
      pend2  = iss_valid && (iss_rd == raddr2);
    end
  end
`else
  // Stored state only: new data and pending clears appear one edge later.
  always_comb begin
    rdata1 = rd_stored1;
    rdata2 = rd_stored2;
    pend1  = pd_stored1;
    pend2  = pd_stored2;
  end
`endif

endmodule

// File: tb/tb_ky32_regfile.sv
// tb_ky32_regfile: self-checking bench for ky32_regfile.
// Latency: directed scenarios plus randomized traffic against an array-based reference model.
// Backpressure: none; inputs driven 1 time unit after each rising edge, outputs checked before the next.
module tb_ky32_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            pend1;
  logic            pend2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural register values and outstanding destinations.
  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_pend [NREG];

  ky32_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  // Apply one clock edge's worth of architectural effects to the model.
  function automatic void model_edge();
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 0) m_reg[waddr] = wdata;
      if (we) m_pend[waddr] = 1'b0;
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endfunction

  // What a read port must show right now, given stored model state and current inputs.
  function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef KY32_RF_BYPASS_EN
    if (rst_n && we && waddr != 0 && a == waddr) return wdata;
`endif
    return m_reg[a];
  endfunction

  function automatic logic model_pd(input logic [AW-1:0] a);
`ifdef KY32_RF_BYPASS_EN
    if (rst_n && we && waddr != 0 && a == waddr) return iss_valid && (iss_rd == a);
`endif
    return m_pend[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); raddr1 = '0; raddr2 = '0;
    tick();
    rst_n = 1'b1;
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    idle_inputs(); raddr1 = 5;
    #1;
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL reset_prewrite: got %h want %h", rdata1, 32'hDEADBEEF); end
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (rdata1 !== '0 || pend1 !== 1'b0) begin n_bad++; $display("FAIL reset_r5: got %h/%b want 0/0", rdata1, pend1); end
    for (int a = 0; a < NREG; a++) begin
      raddr2 = AW'(a);
      #1;
      n_cmp++;
      if (rdata2 !== '0 || pend2 !== 1'b0) begin n_bad++; $display("FAIL reset_sweep r%0d: got %h/%b want 0/0", a, rdata2, pend2); end
    end
    rst_n = 1'b1;
    we = 1'b1; waddr = 5; wdata = 32'h12345678;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rdata1 !== 32'h12345678) begin n_bad++; $display("FAIL reset_release_write: got %h want %h", rdata1, 32'h12345678); end
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0; raddr2 = 0;
    iss_valid = 1'b1; iss_rd = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (rdata1 !== '0 || rdata2 !== '0 || pend1 !== 1'b0 || pend2 !== 1'b0) begin
        n_bad++; $display("FAIL r0_zero cyc%0d: got %h %h %b %b want 0 0 0 0", c, rdata1, rdata2, pend1, pend2);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    we = 1'b1; waddr = 7; wdata = 32'h11;
    tick();
    wdata = 32'hA5A5A5A5; raddr1 = 7; raddr2 = 7;
    #1;
    n_cmp++;
`ifdef KY32_RF_BYPASS_EN
    if (rdata1 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL same_cycle_bypass: got %h want %h", rdata1, 32'hA5A5A5A5); end
`else
    if (rdata1 !== 32'h11) begin n_bad++; $display("FAIL same_cycle_old: got %h want %h", rdata1, 32'h11); end
`endif
    n_cmp++;
    if (rdata2 !== rdata1) begin n_bad++; $display("FAIL same_addr_ports: got %h want %h", rdata2, rdata1); end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rdata1 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL same_cycle_after: got %h want %h", rdata1, 32'hA5A5A5A5); end
  endtask

  task automatic test_scoreboard();
    raddr1 = 3;
    iss_valid = 1'b1; iss_rd = 3;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (pend1 !== 1'b1) begin n_bad++; $display("FAIL sb_pending cyc%0d: got %b want 1", c, pend1); end
      if (c < 3) tick();
    end
    we = 1'b1; waddr = 3; wdata = 32'hCAFE0003;
    #1;
    n_cmp++;
`ifdef KY32_RF_BYPASS_EN
    if (pend1 !== 1'b0) begin n_bad++; $display("FAIL sb_clear_bypass: got %b want 0", pend1); end
`else
    if (pend1 !== 1'b1) begin n_bad++; $display("FAIL sb_clear_nobypass: got %b want 1", pend1); end
`endif
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (pend1 !== 1'b0 || rdata1 !== 32'hCAFE0003) begin n_bad++; $display("FAIL sb_cleared: got %b/%h want 0/%h", pend1, rdata1, 32'hCAFE0003); end
  endtask

  task automatic test_set_clear_collision();
    raddr1 = 9;
    iss_valid = 1'b1; iss_rd = 9;
    tick();
    we = 1'b1; waddr = 9; wdata = 32'h99990009;
    #1;
    n_cmp++;
    if (pend1 !== 1'b1) begin n_bad++; $display("FAIL collide_same_cycle: got %b want 1", pend1); end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (pend1 !== 1'b1 || rdata1 !== 32'h99990009) begin n_bad++; $display("FAIL collide_after: got %b/%h want 1/%h", pend1, rdata1, 32'h99990009); end
    // A write to a register nobody issued: data lands, bit stays clear.
    raddr2 = 20; we = 1'b1; waddr = 20; wdata = 32'h20202020;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (pend2 !== 1'b0 || rdata2 !== 32'h20202020) begin n_bad++; $display("FAIL write_unpending: got %b/%h want 0/%h", pend2, rdata2, 32'h20202020); end
  endtask

  task automatic test_reset_mid();
    raddr1 = 12;
    we = 1'b1; waddr = 12; wdata = 32'h77;
    iss_valid = 1'b1; iss_rd = 12;
    tick();
    // Reset edge with a write and an issue presented: both must be dropped.
    rst_n = 1'b0; we = 1'b1; waddr = 12; wdata = 32'hBAD; iss_valid = 1'b1; iss_rd = 12;
    tick();
    rst_n = 1'b1; idle_inputs();
    #1;
    n_cmp++;
    if (pend1 !== 1'b0 || rdata1 !== '0) begin n_bad++; $display("FAIL reset_mid: got %b/%h want 0/0", pend1, rdata1); end
    we = 1'b1; waddr = 12; wdata = 32'h42;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rdata1 !== 32'h42) begin n_bad++; $display("FAIL reset_mid_write: got %h want %h", rdata1, 32'h42); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e1, e2;
    logic ep1, ep2;
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      we        = $urandom_range(0, 1) == 1;
      iss_valid = $urandom_range(0, 2) == 0;
      // Narrow address range half the time so hits and collisions are frequent.
      if ($urandom_range(0, 1) == 1) begin
        waddr = AW'($urandom_range(0, 3)); iss_rd = AW'($urandom_range(0, 3));
        raddr1 = AW'($urandom_range(0, 3)); raddr2 = AW'($urandom_range(0, 3));
      end else begin
        waddr = AW'($urandom); iss_rd = AW'($urandom);
        raddr1 = AW'($urandom); raddr2 = AW'($urandom);
      end
      wdata = $urandom;
      #1;
      e1 = model_rd(raddr1); e2 = model_rd(raddr2);
      ep1 = model_pd(raddr1); ep2 = model_pd(raddr2);
      n_cmp++;
      if (rdata1 !== e1 || rdata2 !== e2 || pend1 !== ep1 || pend2 !== ep2) begin
        n_bad++;
        $display("FAIL random cyc%0d a1=%0d a2=%0d: got %h %h %b %b want %h %h %b %b",
                 c, raddr1, raddr2, rdata1, rdata2, pend1, pend2, e1, e2, ep1, ep2);
      end
      tick();
    end
    rst_n = 1'b1; idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
    rst_n = 1'b0; idle_inputs(); raddr1 = '0; raddr2 = '0;
    #1;
    test_reset();
    test_r0();
    test_same_cycle();
    test_scoreboard();
    test_set_clear_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
